// File: rtl/bin_magnitude.sv
// Sweeps the SDFT bin arrays once per start pulse and writes an alpha-max/beta-min
// magnitude estimate of every bin, scaled and saturated, into the frequency BRAM.
module bin_magnitude #(
  parameter int freq_bins = 16,
  parameter int bin_w     = 16,
  parameter int data_w    = 8,
  parameter int addr_w    = 8,
  parameter int shift     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [$clog2(freq_bins)-1:0] bin_addr,
  input  logic signed [bin_w-1:0]      bin_real,
  input  logic signed [bin_w-1:0]      bin_imag,
  output logic                         w_en,
  output logic [addr_w-1:0]            w_addr,
  output logic [data_w-1:0]            d_out,
  output logic                         busy,
  output logic                         done
);

  localparam int kw = $clog2(freq_bins);
  localparam logic [kw-1:0] last_k = kw'(freq_bins - 1);
  localparam logic [bin_w+1:0] sat_max = (bin_w + 2)'((64'd1 << data_w) - 64'd1);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [kw-1:0]       k;
  logic [kw-1:0]       k_next;
  logic [bin_w+1:0]    mag;
  logic [bin_w+1:0]    mag_calc;
  logic [bin_w+1:0]    scaled;
  logic [data_w-1:0]   sat_val;
  logic signed [bin_w:0] re_ext;
  logic signed [bin_w:0] im_ext;
  logic [bin_w:0]      re_abs;
  logic [bin_w:0]      im_abs;
  logic [bin_w:0]      mag_max;
  logic [bin_w:0]      mag_min;

  // One extra bit keeps |-2^(bin_w-1)| representable; one more holds max + min/2.
  always_comb begin
    re_ext   = bin_real;
    im_ext   = bin_imag;
    re_abs   = re_ext[bin_w] ? $unsigned(-re_ext) : $unsigned(re_ext);
    im_abs   = im_ext[bin_w] ? $unsigned(-im_ext) : $unsigned(im_ext);
    mag_max  = (re_abs >= im_abs) ? re_abs : im_abs;
    mag_min  = (re_abs >= im_abs) ? im_abs : re_abs;
    mag_calc = {1'b0, mag_max} + ({1'b0, mag_min} >> 1);
    scaled   = mag >> shift;
    sat_val  = (scaled > sat_max) ? {data_w{1'b1}} : scaled[data_w-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      mag   <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (state == CALC) mag <= mag_calc;
    end
  end

  // k only moves on entry to a sweep or after a write, so bin_addr = k holds outside FETCH.
  always_comb begin
    state_next = state;
    k_next     = k;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          k_next     = '0;
        end
      end
      FETCH: state_next = CALC;
      CALC:  state_next = WRITE;
      WRITE: begin
        if (k == last_k) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
          k_next     = k + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bin_addr = k;
    busy     = (state != IDLE);
    done     = (state == DONE);
    w_en     = (state == WRITE);
    w_addr   = w_en ? addr_w'(k) : '0;
    d_out    = w_en ? sat_val : '0;
  end

endmodule

// File: tb/tb_bin_magnitude.sv
// Directed bench for bin_magnitude: a cycle-phase model of each sweep is compared
// against the DUT every cycle, alongside hand-computed literal checks per scenario.
module tb_bin_magnitude;

  localparam int N      = 16;
  localparam int BIN_W  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int SHIFT  = 1;
  localparam int KW     = $clog2(N);
  localparam int SWEEP  = 3 * N + 1;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic [KW-1:0]            bin_addr;
  logic signed [BIN_W-1:0]  bin_real = '0;
  logic signed [BIN_W-1:0]  bin_imag = '0;
  logic                     w_en;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        d_out;
  logic                     busy;
  logic                     done;

  logic signed [BIN_W-1:0]  re_mem [N];
  logic signed [BIN_W-1:0]  im_mem [N];

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  logic m_active = 1'b0;
  int   m_phase  = 0;

  bin_magnitude #(
    .freq_bins(N), .bin_w(BIN_W), .data_w(DATA_W), .addr_w(ADDR_W), .shift(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bin_addr(bin_addr),
    .bin_real(bin_real), .bin_imag(bin_imag), .w_en(w_en), .w_addr(w_addr),
    .d_out(d_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered-read SDFT bin arrays
  always @(posedge clk) begin
    bin_real <= re_mem[bin_addr];
    bin_imag <= im_mem[bin_addr];
  end

  function automatic int expMag(input int re, input int im);
    int a, b, m;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    m = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
    m = m / (1 << SHIFT);
    return (m > (1 << DATA_W) - 1) ? (1 << DATA_W) - 1 : m;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkZero(input string name);
    checkOutput({name, " busy"}, int'(busy), 0);
    checkOutput({name, " done"}, int'(done), 0);
    checkOutput({name, " w_en"}, int'(w_en), 0);
    checkOutput({name, " w_addr"}, int'(w_addr), 0);
    checkOutput({name, " d_out"}, int'(d_out), 0);
    checkOutput({name, " bin_addr"}, int'(bin_addr), 0);
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    start = s;
    reset = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic fillBins(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      re_mem[i] = BIN_W'(re);
      im_mem[i] = BIN_W'(im);
    end
  endtask

  // Starts a sweep, optionally pokes start/reset at given cycles, and tallies writes.
  task automatic runSweep(input string name, input int exp_d, input int poke1,
                          input int poke2, input int rst_rel,
                          input int exp_writes, input int exp_dones);
    int writes = 0;
    int dones = 0;
    int done_rel = -1;
    int first_w = -1;
    applyStimulus(1'b1, 1'b0);
    for (int rel = 1; rel <= SWEEP + 6; rel++) begin
      @(negedge clk);
      if (w_en) begin
        if (first_w < 0) first_w = rel;
        checkOutput({name, " w_addr order"}, int'(w_addr), writes);
        if (exp_d >= 0) checkOutput({name, " d_out"}, int'(d_out), exp_d);
        writes++;
      end
      if (done) begin
        dones++;
        done_rel = rel;
      end
      if (rst_rel >= 0 && rel == rst_rel + 1) checkZero({name, " after reset"});
      start = (rel == poke1 || rel == poke2);
      reset = (rel == rst_rel);
    end
    start = 1'b0;
    reset = 1'b0;
    checkOutput({name, " write count"}, writes, exp_writes);
    checkOutput({name, " done count"}, dones, exp_dones);
    checkOutput({name, " first write cycle"}, first_w, 3);
    if (exp_dones > 0) checkOutput({name, " done cycle"}, done_rel, SWEEP);
  endtask

  // Sweep timing model: phase counts cycles since the accepted start pulse.
  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_phase  <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_phase  <= 1;
      end
    end else if (m_phase == SWEEP) begin
      m_active <= 1'b0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int  idx;
      logic exp_wen;
      exp_wen = m_active && (m_phase % 3 == 0) && (m_phase <= 3 * N);
      checkOutput("model busy", int'(busy), int'(m_active));
      checkOutput("model done", int'(done), int'(m_active && m_phase == SWEEP));
      checkOutput("model w_en", int'(w_en), int'(exp_wen));
      if (exp_wen) begin
        idx = m_phase / 3 - 1;
        checkOutput("model w_addr", int'(w_addr), idx);
        checkOutput("model d_out", int'(d_out),
                    expMag(int'(re_mem[idx]), int'(im_mem[idx])));
      end
      if (m_active && (m_phase % 3 == 1) && (m_phase <= 3 * N - 2))
        checkOutput("model bin_addr", int'(bin_addr), (m_phase - 1) / 3);
    end
  end

  initial begin
    fillBins(0, 0);
    checkOutput("model pin 100/-40", expMag(100, -40), 60);
    checkOutput("model pin max neg", expMag(-32768, -32768), 255);
    checkOutput("model pin 3/-3", expMag(3, -3), 2);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    checkZero("reset state");

    $display("[TB] sweep re=100 im=-40");
    fillBins(100, -40);
    runSweep("basic", 60, -1, -1, -1, N, 1);

    $display("[TB] sweep re=im=-32768");
    fillBins(-32768, -32768);
    runSweep("saturate", 255, -1, -1, -1, N, 1);

    $display("[TB] sweep zero and small bins");
    fillBins(0, 0);
    runSweep("zero", 0, -1, -1, -1, N, 1);
    fillBins(3, -3);
    runSweep("small", 2, -1, -1, -1, N, 1);

    $display("[TB] start pulses while busy and during DONE");
    fillBins(100, -40);
    runSweep("retrigger", 60, 10, SWEEP, -1, N, 1);

    $display("[TB] reset in the middle of a sweep");
    runSweep("abort", 60, -1, -1, 20, 6, 0);

    $display("[TB] reset and start on the same edge");
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("reset beats start busy", int'(busy), 0);

    $display("[TB] fresh sweep with varied bins");
    for (int i = 0; i < N; i++) begin
      re_mem[i] = BIN_W'(i * 4111 - 30000);
      im_mem[i] = BIN_W'(20000 - i * 2900);
    end
    runSweep("varied", -1, -1, -1, -1, N, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_magnitude.md
BIN_MAGNITUDE -- requirements
Module: bin_magnitude

Interface
REQ-001 The block SHALL have parameter freq_bins, default 16: number of SDFT frequency bins to process.
REQ-002 The block SHALL have parameter bin_w, default 16: width of each signed real/imag bin value.
REQ-003 The block SHALL have parameter data_w, default 8: width of the magnitude word written to the frequency BRAM.
REQ-004 The block SHALL have parameter addr_w, default 8: BRAM write address width.
REQ-005 The block SHALL have parameter shift, default 1: right-shift applied to the raw magnitude before saturation.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle pulse from sdft meaning all bins are updated.
REQ-009 The block SHALL have port bin_addr, output, $clog2(freq_bins) bits: read index into the sdft bin arrays.
REQ-010 The block SHALL have port bin_real, input, bin_w bits, signed: sdft real part, valid one cycle after bin_addr (registered read).
REQ-011 The block SHALL have port bin_imag, input, bin_w bits, signed: sdft imaginary part, same timing as bin_real.
REQ-012 The block SHALL have port w_en, output, 1 bit: BRAM write enable.
REQ-013 The block SHALL have port w_addr, output, addr_w bits: BRAM write address.
REQ-014 The block SHALL have port d_out, output, data_w bits: BRAM write data.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bin is written.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, CALC, WRITE and DONE.
REQ-018 IDLE SHALL go to FETCH with bin counter k=0 on the cycle after start=1 is sampled; with start=0 it SHALL stay in IDLE.
REQ-019 In FETCH the block SHALL drive bin_addr=k and go to CALC.
REQ-020 In CALC the block SHALL take bin_real/bin_imag as |re|, |im| at bin_w+1 bits, so that -2^(bin_w-1) maps to +2^(bin_w-1) without overflow.
REQ-021 In CALC the block SHALL register mag = max(|re|,|im|) + (min(|re|,|im|) >> 1) at bin_w+2 bits, then go to WRITE.
REQ-022 The scaled value SHALL be s = mag >> shift; d_out SHALL be s when s <= 2^data_w-1, else 2^data_w-1 (saturate, never wrap).
REQ-023 In WRITE the block SHALL drive w_en=1, w_addr=k zero-extended and d_out=scaled mag, all for exactly one cycle.
REQ-024 From WRITE the block SHALL go to FETCH with k+1 when k<freq_bins-1, else to DONE.
REQ-025 In DONE the block SHALL drive done=1 for one cycle, then return to IDLE.
REQ-026 Latency: start sampled at cycle 0 gives first w_en at cycle 3, writes every 3 cycles, and done at cycle 3*freq_bins+1 (49 for the defaults).
REQ-027 A start pulse while busy=1, including during DONE, SHALL be ignored and not queued.
REQ-028 Bins SHALL be written in ascending order 0..freq_bins-1 with no skips or repeats; w_en SHALL be 0 outside WRITE.
REQ-029 bin_addr SHALL hold its last value outside FETCH.

Reset
REQ-030 When reset=1 at a rising edge, the next state SHALL be IDLE with k=0, bin_addr=0, w_en=0, w_addr=0, d_out=0, busy=0 and done=0.
REQ-031 Reset SHALL take priority over start and over any in-progress sweep; an aborted sweep SHALL not resume, and no w_en SHALL be issued after the reset edge.

Verification
REQ-032 Bench SHALL hold all bins at re=100, im=-40 and pulse start, and SHALL see 16 writes, each with d_out=60 ((100+20)>>1), w_addr 0..15 in order, and done at cycle 49.
REQ-033 Bench SHALL set re=-32768, im=-32768 and SHALL see d_out=255 (49152>>1 saturated).
REQ-034 Bench SHALL set re=0, im=0 and SHALL see d_out=0; it SHALL set re=3, im=-3 and SHALL see d_out=2 ((3+1)>>1).
REQ-035 Bench SHALL pulse start again at cycle 10 of a sweep and SHALL see exactly 16 writes and one done pulse.
REQ-036 Bench SHALL assert reset at cycle 20 of a sweep and SHALL see all outputs 0 and busy=0 the next cycle, with no further w_en until a new start; a fresh start SHALL then yield a full 16-bin sweep.
